// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the memory stage and its MEM/WB register.
//   mem_state_t : memory-stage access FSM states
//   WB_SEL_*    : write-back data select encodings (both 00 and 01 pick PC+4)
//   REG_ADDR_W  : register-file address width
//   word_aligned: true when the low two address bits are zero
package cpu_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] WB_SEL_PC     = 2'b00;
   localparam logic [1:0] WB_SEL_PC_ALT = 2'b01;
   localparam logic [1:0] WB_SEL_MEM    = 2'b10;
   localparam logic [1:0] WB_SEL_EXE    = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCESS    = 2'd1,
      WAIT_DATA = 2'd2
   } mem_state_t;

   function automatic logic word_aligned(input logic [1:0] lsbs);
      return (lsbs == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load enable and bubble insert.
//   i_load     : capture a valid entry this edge; otherwise a bubble is inserted
//                (valid/regwrite/err cleared, data fields hold)
//   i_mem_ld   : also capture i_mem into o_mem (load completion only)
//   i_regwrite, i_err, i_exe, i_mem, i_pc, i_rx, i_lr, i_wbsel, i_wbreg : entry fields
//   o_*        : registered fields consumed by write-back
module mem_wb_reg
   import cpu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_mem_ld,
   input  logic                  i_regwrite,
   input  logic                  i_err,
   input  logic [N-1:0]          i_exe,
   input  logic [N-1:0]          i_mem,
   input  logic [N-1:0]          i_pc,
   input  logic [REG_ADDR_W-1:0] i_rx,
   input  logic [REG_ADDR_W-1:0] i_lr,
   input  logic [1:0]            i_wbsel,
   input  logic                  i_wbreg,
   output logic                  o_valid,
   output logic                  o_regwrite,
   output logic                  o_err,
   output logic [N-1:0]          o_exe,
   output logic [N-1:0]          o_mem,
   output logic [N-1:0]          o_pc,
   output logic [REG_ADDR_W-1:0] o_rx,
   output logic [REG_ADDR_W-1:0] o_lr,
   output logic [1:0]            o_wbsel,
   output logic                  o_wbreg
);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid    <= 1'b0;
         o_regwrite <= 1'b0;
         o_err      <= 1'b0;
         o_exe      <= '0;
         o_mem      <= '0;
         o_pc       <= '0;
         o_rx       <= '0;
         o_lr       <= '0;
         o_wbsel    <= '0;
         o_wbreg    <= 1'b0;
      end else begin
         // control bits are cleared on a bubble so write-back never acts on stale data
         o_valid    <= i_load;
         o_regwrite <= i_load & i_regwrite;
         o_err      <= i_load & i_err;
         if (i_load) begin
            o_exe   <= i_exe;
            o_pc    <= i_pc;
            o_rx    <= i_rx;
            o_lr    <= i_lr;
            o_wbsel <= i_wbsel;
            o_wbreg <= i_wbreg;
            if (i_mem_ld) o_mem <= i_mem;
         end
      end
   end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Runs the req/ack (and rvalid for loads)
// handshake with the memory controller, stalls upstream while an access is in
// flight, and registers the MEM/WB entry for write-back.
//   EX side  : in_valid, ExeOutIn, StoreData, MemRead, MemWrite, PCInc4In, RxIn,
//              LRIn, WbDataSelIn, WbRegSelIn, RegWriteIn ; stall back to EX
//   memory   : mem_req, mem_we, mem_addr, mem_wdata -> ; <- mem_ack, mem_rvalid, mem_rdata
//   MEM/WB   : out_valid, ExeOut, MemOut, PCInc4, Rx, LR, WbDataSel, WbRegSel,
//              RegWrite, mem_err
module mem_access
   import cpu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [N-1:0]          ExeOutIn,
   input  logic [N-1:0]          StoreData,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [N-1:0]          PCInc4In,
   input  logic [REG_ADDR_W-1:0] RxIn,
   input  logic [REG_ADDR_W-1:0] LRIn,
   input  logic [1:0]            WbDataSelIn,
   input  logic                  WbRegSelIn,
   input  logic                  RegWriteIn,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [N-1:0]          mem_addr,
   output logic [N-1:0]          mem_wdata,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   input  logic [N-1:0]          mem_rdata,
   output logic                  stall,
   output logic                  out_valid,
   output logic [N-1:0]          ExeOut,
   output logic [N-1:0]          MemOut,
   output logic [N-1:0]          PCInc4,
   output logic [REG_ADDR_W-1:0] Rx,
   output logic [REG_ADDR_W-1:0] LR,
   output logic [1:0]            WbDataSel,
   output logic                  WbRegSel,
   output logic                  RegWrite,
   output logic                  mem_err
);

   mem_state_t       r_state, w_next;
   logic [N-3:0]     r_addr;   // word address; byte offset is always zero here
   logic [N-1:0]     r_wdata;
   logic             r_we;

   logic w_memop, w_bad, w_latch, w_load, w_mem_ld, w_regwrite, w_err;

   // a memory op is faulty if misaligned or both directions are requested
   assign w_bad   = in_valid & (MemRead | MemWrite) &
                    (~word_aligned(ExeOutIn[1:0]) | (MemRead & MemWrite));
   assign w_memop = in_valid & (MemRead ^ MemWrite) & word_aligned(ExeOutIn[1:0]);

   always_comb begin
      w_next     = r_state;
      stall      = 1'b0;
      w_latch    = 1'b0;
      w_load     = 1'b0;
      w_mem_ld   = 1'b0;
      w_regwrite = RegWriteIn;
      w_err      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_memop) begin
               w_latch = 1'b1;
               stall   = 1'b1;
               w_next  = ACCESS;
            end else if (in_valid) begin
               // pass-through, including faulting ops which never reach memory
               w_load     = 1'b1;
               w_err      = w_bad;
               w_regwrite = RegWriteIn & ~w_bad;
            end
         end
         ACCESS: begin
            if (mem_ack && r_we) begin
               w_load = 1'b1;
               w_next = IDLE;
            end else if (mem_ack) begin
               stall  = 1'b1;
               w_next = WAIT_DATA;
            end else begin
               stall  = 1'b1;
            end
         end
         WAIT_DATA: begin
            if (mem_rvalid) begin
               w_load   = 1'b1;
               w_mem_ld = 1'b1;
               w_next   = IDLE;
            end else begin
               stall    = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_addr  <= ExeOutIn[N-1:2];
            r_wdata <= StoreData;
            r_we    <= MemWrite;
         end
      end
   end

   assign mem_req   = (r_state == ACCESS);
   assign mem_we    = r_we;
   assign mem_addr  = {r_addr, 2'b00};
   assign mem_wdata = r_wdata;

   mem_wb_reg #(.N(N)) u_mem_wb (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_mem_ld  (w_mem_ld),
      .i_regwrite(w_regwrite),
      .i_err     (w_err),
      .i_exe     (ExeOutIn),
      .i_mem     (mem_rdata),
      .i_pc      (PCInc4In),
      .i_rx      (RxIn),
      .i_lr      (LRIn),
      .i_wbsel   (WbDataSelIn),
      .i_wbreg   (WbRegSelIn),
      .o_valid   (out_valid),
      .o_regwrite(RegWrite),
      .o_err     (mem_err),
      .o_exe     (ExeOut),
      .o_mem     (MemOut),
      .o_pc      (PCInc4),
      .o_rx      (Rx),
      .o_lr      (LR),
      .o_wbsel   (WbDataSel),
      .o_wbreg   (WbRegSel)
   );

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed stimulus with a scoreboard. Issued instructions push
// expected MEM/WB entries and expected memory requests; a monitor pops entries
// on out_valid and a responder checks requests while acting as the controller.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] ExeOutIn, StoreData, PCInc4In;
   logic        MemRead, MemWrite;
   logic [4:0]  RxIn, LRIn;
   logic [1:0]  WbDataSelIn;
   logic        WbRegSelIn, RegWriteIn;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        stall, out_valid;
   logic [31:0] ExeOut, MemOut, PCInc4;
   logic [4:0]  Rx, LR;
   logic [1:0]  WbDataSel;
   logic        WbRegSel, RegWrite, mem_err;

   mem_access #(.N(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ExeOutIn(ExeOutIn),
      .StoreData(StoreData), .MemRead(MemRead), .MemWrite(MemWrite),
      .PCInc4In(PCInc4In), .RxIn(RxIn), .LRIn(LRIn), .WbDataSelIn(WbDataSelIn),
      .WbRegSelIn(WbRegSelIn), .RegWriteIn(RegWriteIn), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall(stall), .out_valid(out_valid), .ExeOut(ExeOut), .MemOut(MemOut),
      .PCInc4(PCInc4), .Rx(Rx), .LR(LR), .WbDataSel(WbDataSel),
      .WbRegSel(WbRegSel), .RegWrite(RegWrite), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exe, mem, pc;
      logic [4:0]  rx, lr;
      logic [1:0]  wbs;
      logic        wbr, rw, err;
      int          t0, lat;
   } exp_t;

   typedef struct {
      logic [31:0] addr, wdata;
      logic        we;
   } req_t;

   exp_t exp_q[$];
   req_t rq_q[$];

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int ack_dly = 0, rv_dly = 1, spur_cyc = -1;
   logic [31:0] rd_data = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   // Memory controller model; also checks requests against the expected queue.
   int req_cnt = 0, rv_cnt = -1;
   initial begin
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      forever begin
         @(posedge clk); #2;
         mem_ack = 1'b0; mem_rvalid = 1'b0;
         if (rst) begin
            req_cnt = 0; rv_cnt = -1;
         end else begin
            if (cyc == spur_cyc) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
            if (rv_cnt > 0) begin
               rv_cnt--;
               if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rd_data; rv_cnt = -1; end
            end
            if (mem_req) begin
               if (rq_q.size() == 0) fail_now("req_unexpected");
               else begin
                  chk("req_addr", mem_addr, rq_q[0].addr);
                  chk("req_we", {31'h0, mem_we}, {31'h0, rq_q[0].we});
                  chk("req_wdata", mem_wdata, rq_q[0].wdata);
               end
               if (req_cnt == ack_dly) begin
                  mem_ack = 1'b1; req_cnt = 0;
                  if (rq_q.size() > 0) void'(rq_q.pop_front());
                  if (!mem_we) rv_cnt = rv_dly;
               end else req_cnt++;
            end else req_cnt = 0;
         end
      end
   end

   // Output monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) fail_now("out_unexpected");
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ExeOut", ExeOut, e.exe);
               chk("MemOut", MemOut, e.mem);
               chk("PCInc4", PCInc4, e.pc);
               chk("Rx", {27'h0, Rx}, {27'h0, e.rx});
               chk("LR", {27'h0, LR}, {27'h0, e.lr});
               chk("WbDataSel", {30'h0, WbDataSel}, {30'h0, e.wbs});
               chk("WbRegSel", {31'h0, WbRegSel}, {31'h0, e.wbr});
               chk("RegWrite", {31'h0, RegWrite}, {31'h0, e.rw});
               chk("mem_err", {31'h0, mem_err}, {31'h0, e.err});
               if (e.lat > 0) chk("latency", cyc - e.t0, e.lat);
            end
         end else begin
            chk("bubble_RegWrite", {31'h0, RegWrite}, 32'h0);
            chk("bubble_mem_err", {31'h0, mem_err}, 32'h0);
         end
      end
   end

   // Present one instruction and hold it until stall drops.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] exe,
                        input logic [31:0] sd, input logic [4:0] rx, input logic rw,
                        input logic [31:0] exp_mem, input logic exp_err,
                        input logic exp_req, input int lat, input int exp_st);
      exp_t e;
      req_t r;
      int   n_st;
      logic done;
      @(posedge clk); #1;
      in_valid = 1'b1; MemRead = rd; MemWrite = wr; ExeOutIn = exe; StoreData = sd;
      PCInc4In = 32'h0000_4000 ^ exe; RxIn = rx; LRIn = rx + 5'd1;
      WbDataSelIn = rd ? 2'b10 : 2'b11; WbRegSelIn = rx[0]; RegWriteIn = rw;
      e.exe = exe; e.mem = exp_mem; e.pc = 32'h0000_4000 ^ exe; e.rx = rx; e.lr = rx + 5'd1;
      e.wbs = rd ? 2'b10 : 2'b11; e.wbr = rx[0]; e.rw = exp_err ? 1'b0 : rw; e.err = exp_err;
      e.t0 = cyc; e.lat = lat;
      exp_q.push_back(e);
      if (exp_req) begin
         r.addr = exe; r.wdata = sd; r.we = wr;
         rq_q.push_back(r);
      end
      n_st = 0; done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (!stall) done = 1'b1; else n_st++;
      end
      if (!done) fail_now("stall_timeout");
      if (exp_st >= 0) chk("stall_cycles", n_st, exp_st);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
      chk({tag, "_ExeOut"}, ExeOut, 32'h0);
      chk({tag, "_MemOut"}, MemOut, 32'h0);
      chk({tag, "_PCInc4"}, PCInc4, 32'h0);
      chk({tag, "_RegWrite"}, {31'h0, RegWrite}, 32'h0);
      chk({tag, "_mem_err"}, {31'h0, mem_err}, 32'h0);
      chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
      chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      ExeOutIn = '0; StoreData = '0; PCInc4In = '0; RxIn = '0; LRIn = '0;
      WbDataSelIn = '0; WbRegSelIn = 1'b0; RegWriteIn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      // non-memory op: 1-cycle latency, never stalls
      issue(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0, 1'b0, 1, 0);
      idle(2);

      // store, ack 2 cycles after mem_req rises
      ack_dly = 2;
      issue(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h0, 1'b0, 1'b1, 4, 3);
      idle(2);

      // load, ack after 1 cycle, rvalid 3 cycles after ack
      ack_dly = 1; rv_dly = 3; rd_data = 32'hCAFE_F00D;
      issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd5, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 6, 5);
      idle(2);

      // back-to-back load then store at minimum latency
      ack_dly = 0; rv_dly = 1; rd_data = 32'h1122_3344;
      issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd6, 1'b1, 32'h1122_3344, 1'b0, 1'b1, 3, 2);
      issue(1'b0, 1'b1, 32'h0000_0304, 32'h5555_AAAA, 5'd7, 1'b0, 32'h1122_3344, 1'b0, 1'b1, 2, 1);
      idle(2);

      // misaligned load: no request, error pulse, RegWrite suppressed
      issue(1'b1, 1'b0, 32'h0000_0202, 32'h0, 5'd8, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 1, 0);
      // both MemRead and MemWrite: also a fault
      issue(1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd9, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 1, 0);
      idle(1);
      spur_cyc = cyc + 1;   // stray rvalid while IDLE
      idle(3);
      issue(1'b0, 1'b0, 32'h0000_0777, 32'h0, 5'd10, 1'b1, 32'h1122_3344, 1'b0, 1'b0, 1, 0);
      idle(2);

      // reset while in WAIT_DATA, then a late rvalid
      ack_dly = 0; rv_dly = 50;
      begin
         req_t r;
         r.addr = 32'h0000_0500; r.wdata = 32'h0; r.we = 1'b0;
         @(posedge clk); #1;
         in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ExeOutIn = 32'h0000_0500;
         RegWriteIn = 1'b1;
         rq_q.push_back(r);
         @(posedge clk); #1;   // ACCESS, acked
         @(posedge clk); #1;   // WAIT_DATA
         rst = 1'b1; in_valid = 1'b0; MemRead = 1'b0;
         spur_cyc = cyc + 1;
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         chk_all_zero("rst_wait");
         @(negedge clk);
         chk_all_zero("post_rst");
      end
      idle(4);

      chk("exp_queue_empty", exp_q.size(), 0);
      chk("req_queue_empty", rq_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the CPU pipeline, directly upstream of write-back.
- Takes the execute result and control from EX.
- For loads and stores, runs a request/acknowledge handshake with the external memory controller and stalls the pipeline until the access completes.
- Registers ExeOut, MemOut, PCInc4, Rx, LR, WbDataSel, WbRegSel into the MEM/WB boundary that feeds write-back.

Parameters:
- N, 32, datapath/address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high; one clock domain
- in_valid  input  1  EX stage presents a valid instruction
- ExeOutIn  input  N  ALU result; effective address for loads/stores
- StoreData  input  N  store data
- MemRead  input  1  load
- MemWrite  input  1  store
- PCInc4In  input  N  PC+4
- RxIn  input  5  destination register
- LRIn  input  5  link register address
- WbDataSelIn  input  2  write-back data select
- WbRegSelIn  input  1  write-back register select
- RegWriteIn  input  1  instruction writes the register file
- mem_req  output  1  request to memory controller
- mem_we  output  1  1 = write
- mem_addr  output  N  word-aligned address
- mem_wdata  output  N  store data
- mem_ack  input  1  controller accepted the request
- mem_rvalid  input  1  read data valid
- mem_rdata  input  N  read data
- stall  output  1  hold EX and earlier stages
- out_valid  output  1  MEM/WB entry valid
- ExeOut  output  N  registered ALU result
- MemOut  output  N  registered load data
- PCInc4  output  N  registered PC+4
- Rx  output  5  registered destination register
- LR  output  5  registered link register address
- WbDataSel  output  2  registered write-back data select
- WbRegSel  output  1  registered write-back register select
- RegWrite  output  1  registered write enable
- mem_err  output  1  one-cycle pulse with the faulting MEM/WB entry

Behaviour:
- Reset values: all outputs 0; state IDLE.
- FSM states: IDLE, ACCESS, WAIT_DATA.
- IDLE:
  - in_valid with exactly one of MemRead/MemWrite and ExeOutIn[1:0]==0 → latch address, store data and direction; go to ACCESS; stall=1.
  - Any other valid instruction passes straight through: MEM/WB registers load at the next edge (1-cycle latency), stall=0.
- ACCESS:
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the latched values and are held stable until mem_ack.
  - Store with mem_ack → stall=0 in that cycle; capture MEM/WB at the edge; return to IDLE.
  - Load with mem_ack → go to WAIT_DATA; mem_req drops the next cycle.
  - mem_rvalid is ignored while in ACCESS.
- WAIT_DATA:
  - mem_req=0; stall=1 until mem_rvalid.
  - On mem_rvalid: stall=0 (combinational); MemOut←mem_rdata and the other MEM/WB fields load at the edge; return to IDLE.
- Minimum latency: store 2 cycles and load 3 cycles from presentation to out_valid; otherwise unbounded while waiting on the controller.
- Bubbles:
  - While stall=1, MEM/WB loads a bubble: out_valid=0, RegWrite=0, other fields hold their previous values.
  - in_valid=0 also produces a bubble.
- Error case: misaligned address or MemRead&MemWrite both set.
  - No request is issued.
  - Next cycle: out_valid=1, mem_err=1, RegWrite=0, other fields pass through.
- Upstream holds its inputs stable while stall=1; the block uses only the values latched on entry to ACCESS.
- MemOut holds its last value for non-load instructions.
- mem_rvalid or mem_ack arriving in IDLE is ignored.
- Reset mid-access: state→IDLE and mem_req=0 at the reset edge; late responses are ignored.

Decomposition:
- cpu_pkg holds:
  - mem_state_t enum (IDLE, ACCESS, WAIT_DATA).
  - Write-back select constants: WB_SEL_PC=2'b00/2'b01, WB_SEL_MEM=2'b10, WB_SEL_EXE=2'b11.
  - REG_ADDR_W=5.
- One natural sub-module: mem_wb_reg.
  - Parameterised pipeline register with load enable and bubble insert.
  - Holds the MEM/WB fields consumed by write-back.

Test Plan:
- Non-memory op: ExeOutIn=0x1234, WbDataSelIn=2'b11, RegWriteIn=1 → next cycle out_valid=1, ExeOut=0x1234, stall never asserted.
- Store: address 0x100, StoreData=0xDEADBEEF, mem_ack 2 cycles after mem_req rises → mem_req/mem_we/mem_addr/mem_wdata stable until ack; stall low in the ack cycle; out_valid=1 next cycle with RegWrite passed through.
- Load: address 0x200, ack after 1 cycle, mem_rvalid with 0xCAFEF00D 3 cycles later → MemOut=0xCAFEF00D, out_valid=1 exactly one cycle after rvalid; bubbles (out_valid=0, RegWrite=0) on every stalled cycle.
- Back-to-back load then store with ack in the first request cycle → minimum latencies of 3 and 2 cycles; no lost or duplicated requests.
- Misaligned load at 0x202 → no mem_req; next cycle mem_err=1, out_valid=1, RegWrite=0; a spurious mem_rvalid in IDLE has no effect.
- rst asserted in WAIT_DATA, then mem_rvalid the next cycle → all outputs 0, state IDLE, MemOut unchanged from 0.
